// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared datapath ALU to form {hi, lo}.
// Define MUL_SIGNED_EN to add the ABS/NEG states for signed (MULT) operation.
module alu_mul_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             c_out
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DONE   = 3'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] S_ABS_A  = 3'd3;
    localparam logic [2:0] S_ABS_B  = 3'd4;
    localparam logic [2:0] S_NEG_LO = 3'd5;
    localparam logic [2:0] S_NEG_HI = 3'd6;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             sgn_q, sgn_d;
    logic             signed_req_s;

`ifdef MUL_SIGNED_EN
    assign signed_req_s = is_signed;
`else
    logic unused_signed_s;
    assign signed_req_s    = 1'b0;
    assign unused_signed_s = ^{is_signed, neg_q, carry_q, sgn_q};
`endif

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            count_q <= {CW{1'b0}};
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            sgn_q   <= sgn_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef MUL_SIGNED_EN
                    state_d = signed_req_s ? S_ABS_A : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (count_q == LAST_STEP) begin
`ifdef MUL_SIGNED_EN
                    state_d = sgn_q ? S_NEG_LO : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:   state_d = S_IDLE;
`ifdef MUL_SIGNED_EN
            S_ABS_A:  state_d = S_ABS_B;
            S_ABS_B:  state_d = S_RUN;
            S_NEG_LO: state_d = S_NEG_HI;
            S_NEG_HI: state_d = S_DONE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath register updates; each state consumes the ALU result it requested
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        sgn_d   = sgn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = op_b;
                    count_d = {CW{1'b0}};
                    neg_d   = signed_req_s & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    sgn_d   = signed_req_s;
                end else begin
                    mcand_d = mcand_q;
                end
            end
            S_RUN: begin
                // Shift the 65-bit {carry, sum, lo} right by one
                hi_d    = {c_out, alu_out[WIDTH-1:1]};
                lo_d    = {alu_out[0], lo_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
            end
`ifdef MUL_SIGNED_EN
            S_ABS_A: begin
                if (mcand_q[WIDTH-1]) mcand_d = alu_out;
                else                  mcand_d = mcand_q;
            end
            S_ABS_B: begin
                if (lo_q[WIDTH-1]) lo_d = alu_out;
                else               lo_d = lo_q;
            end
            S_NEG_LO: begin
                if (neg_q) begin
                    lo_d    = alu_out;
                    carry_d = c_out;
                end else begin
                    lo_d    = lo_q;
                    carry_d = carry_q;
                end
            end
            S_NEG_HI: begin
                if (neg_q) hi_d = alu_out;
                else       hi_d = hi_q;
            end
`endif
            default: begin
                hi_d = hi_q;
            end
        endcase
    end

    // Status flags and ALU drive, decoded from registers only
    always_comb begin
        ready       = (state_q == S_IDLE);
        done        = (state_q == S_DONE);
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        alu_req     = busy;
        alu_a       = {WIDTH{1'b0}};
        alu_b       = {WIDTH{1'b0}};
        alu_control = 3'b000;
        case (state_q)
            S_RUN: begin
                alu_a       = hi_q;
                alu_b       = lo_q[0] ? mcand_q : {WIDTH{1'b0}};
                alu_control = ALU_ADD;
            end
`ifdef MUL_SIGNED_EN
            S_ABS_A: begin
                alu_b       = mcand_q;
                alu_control = ALU_SUB;
            end
            S_ABS_B: begin
                alu_b       = lo_q;
                alu_control = ALU_SUB;
            end
            S_NEG_LO: begin
                alu_b       = lo_q;
                alu_control = ALU_SUB;
            end
            S_NEG_HI: begin
                alu_a       = ~hi_q;
                alu_b       = {{(WIDTH-1){1'b0}}, carry_q};
                alu_control = ALU_ADD;
            end
`endif
            default: begin
                alu_control = 3'b000;
            end
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle multiply sequencer that borrows the shared 32-bit datapath ALU to compute a 64-bit product {hi, lo} by iterative shift-add (MULT/MULTU support).
- Sits beside the ALU. The top level muxes the ALU inputs to this block while alu_req is high.
- Drives the ALU's a, b and 3-bit control inputs. Consumes alu_out and c_out.
- ALU control codes used: 010 = ADD, 110 = SUB (a + ~b + 1).

Parameters:
- WIDTH, 32, operand width. Must equal the ALU width. Product is 2*WIDTH.
- ALU_ADD, 3'b010, ALU control code for add.
- ALU_SUB, 3'b110, ALU control code for subtract.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request. Sampled only when ready=1.
- is_signed  input  1  signed multiply. Ignored unless MUL_SIGNED_EN is defined.
- op_a  input  WIDTH  multiplicand
- op_b  input  WIDTH  multiplier
- ready  output  1  high in IDLE
- busy  output  1  high in every non-IDLE, non-DONE state
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  upper product word
- lo  output  WIDTH  lower product word
- alu_req  output  1  ALU ownership request. Equals busy.
- alu_a  output  WIDTH  ALU operand a
- alu_b  output  WIDTH  ALU operand b
- alu_control  output  3  ALU opcode
- alu_out  input  WIDTH  ALU result
- c_out  input  1  ALU carry out

Behaviour:
- Reset: reset_n=0 at a clock edge forces the following, from any state including mid-operation:
  - state=IDLE
  - hi=0, lo=0, mcand=0, count=0, neg=0, carry_q=0
  - done=0, busy=0, alu_req=0
- ALU drive when not busy: alu_a=0, alu_b=0, alu_control=3'b000.
- Outputs ready, busy, done and the alu_* signals are combinational from registers only. There is no combinational path from start.
- Accept (start=1 at an edge while IDLE):
  - mcand<=op_a, hi<=0, lo<=op_b, count<=0.
  - neg<=is_signed & (op_a[31]^op_b[31]).
  - Next state: RUN (unsigned) or ABS_A (signed).
- start is ignored in every other state. Operands may change freely after acceptance.
- RUN, one step per cycle:
  - Drive alu_a=hi, alu_b=lo[0] ? mcand : 0, alu_control=ALU_ADD.
  - Update {hi,lo}<={c_out, alu_out, lo[31:1]}, count<=count+1.
  - After the step with count==31, go to DONE (unsigned) or NEG_LO (signed).
- DONE: done=1 for exactly one cycle, then IDLE.
- hi/lo hold their value from DONE until the next accept.
- Unsigned latency: accept edge E0, steps at E1..E32, done high in the cycle after E32, IDLE at E33. ready is low from E0 through the DONE cycle.
- Count wrap: count is 5 bits; the terminal test is count==31, so there is no wrap-around.
- Width rule: the product never exceeds 64 bits. The carry from c_out is the only overflow bit captured per step.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined: is_signed=1 routes through additional states, each one cycle; every state always takes its cycle, giving a fixed latency of 36.
  - ABS_A: alu_a=0, alu_b=mcand, alu_control=ALU_SUB. mcand<=alu_out if mcand[31], else unchanged.
  - ABS_B: same operation applied to lo.
  - RUN: as above.
  - NEG_LO: alu_a=0, alu_b=lo, ALU_SUB. If neg: lo<=alu_out and carry_q<=c_out.
  - NEG_HI: alu_a=~hi, alu_b={31'b0, carry_q}, ALU_ADD. If neg: hi<=alu_out. Then DONE.
  - Signed timing: done in the cycle after E36.
  - -2^31 as an operand yields magnitude 0x80000000, treated as unsigned, which is correct.
- Not defined: is_signed is ignored; all operations are unsigned with latency 32; ABS/NEG states do not exist.

Test Plan:
- Unsigned basic: op_a=7, op_b=6, start at E0 → hi=0, lo=0x0000002A; done pulses one cycle after E32; ready returns at E33.
- Unsigned max: 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. alu_req=1 for exactly 32 cycles.
- Ignored start: hold start=1 and change op_a/op_b throughout RUN → result reflects the operands captured at E0; exactly one done per accepted start.
- Reset mid-run: reset_n=0 at E10 → next cycle state is IDLE with hi=lo=0, busy=done=alu_req=0, ready=1. A fresh start of 3×4 then gives lo=12.
- Back-to-back: start held high continuously → second accept occurs at the IDLE edge after DONE; hi/lo stay stable during the DONE cycle.
- Signed (MUL_SIGNED_EN, is_signed=1):
  - -3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; done after E36.
  - -2^31 × -1 → hi=0, lo=0x80000000.
  - 0 × -7 → hi=0, lo=0, exercising carry_q=1 in NEG_LO.
